zrb_sd_cmd_framer: RTL and testbench

- Upstream byte source and sink for zrb_spi_rxtx.
- Takes one SD-SPI command request (index, argument, response length), builds the 6-byte frame (0b01 + index, arg MSB-first, CRC7 + end bit) and pushes it into the SPI engine's input FIFO.
- Then clocks 0xFF fill bytes, scans the returned bytes for R1, collects optional trailing bytes (R3/R7), and reports done or timeout.

---
 rtl/zrb_sd_cmd_framer_pkg.sv | 35 +++
 rtl/zrb_sd_cmd_framer_if.sv | 18 +
 rtl/zrb_crc7.sv | 21 ++
 rtl/zrb_sd_cmd_framer.sv | 173 +++++++++++++++++
 tb/tb_zrb_sd_cmd_framer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/zrb_sd_cmd_framer_pkg.sv
// zrb_sd_pkg: shared types and constants for the SD-SPI command framer.
//   state_t     framer FSM states
//   constants   frame start bits, fill byte, CRC7 polynomial, R1 bit positions
//   crc7_byte   one byte of the SD CRC7 (x^7+x^3+1), MSB first
package zrb_sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_POLL,
      ST_EXTRA,
      ST_DRAIN,
      ST_FINISH
   } state_t;

   localparam logic [1:0] CMD_START_BITS = 2'b01;
   localparam logic [7:0] FILL_BYTE      = 8'hFF;
   localparam logic [6:0] CRC7_POLY      = 7'h09;
   localparam int         R1_START_BIT   = 7;     // 0 marks a valid R1
   localparam logic [2:0] EXTRA_MAX      = 3'd4;

   function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in,
                                            input logic [7:0] d);
      logic [6:0] c;
      logic       fb;
      c = crc_in;
      for (int i = 7; i >= 0; i--) begin
         fb = c[6] ^ d[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ CRC7_POLY;
      end
      return c;
   endfunction

endpackage

// File: rtl/zrb_sd_cmd_framer_if.sv
// Byte bus between the command framer and the SPI engine FIFOs.
//   tx_valid/tx_data  write into engine input FIFO, tx_full backpressure
//   rx_empty/rx_data  engine output FIFO (first-word-fall-through)
//   rx_read           pop from engine output FIFO
// master = framer side, slave = engine side.
interface zrb_sd_cmd_framer_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_full;
   logic       rx_empty;
   logic [7:0] rx_data;
   logic       rx_read;

   modport master (output tx_valid, tx_data, rx_read,
                   input  tx_full, rx_empty, rx_data);
   modport slave  (input  tx_valid, tx_data, rx_read,
                   output tx_full, rx_empty, rx_data);
endinterface

// File: rtl/zrb_crc7.sv
// Byte-serial SD CRC7 accumulator.
//   clear  zero the accumulator (takes priority over en)
//   en     fold data[7:0] in, one byte per cycle
//   crc    result, valid the cycle after the last en
module zrb_crc7
   import zrb_sd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] data,
   output logic [6:0] crc
);

   always_ff @(posedge clk) begin
      if (!reset || clear) crc <= '0;
      else if (en)         crc <= crc7_byte(crc, data);
   end

endmodule

// File: rtl/zrb_sd_cmd_framer.sv
// SD-SPI command framer: builds the 6-byte command frame, pushes it into the
// SPI engine, polls 0xFF fills for R1, collects up to 4 trailing bytes and
// reports done or timeout.
//   clk, reset            clock, synchronous active-low reset
//   cmd_start/index/arg   command request (sampled in IDLE only)
//   resp_extra            trailing bytes after R1, clamped to 4
//   spi                   byte bus to the SPI engine (master side)
//   busy/done/timeout     status; done/timeout are one-cycle pulses
//   r1, resp_data         captured response
module zrb_sd_cmd_framer
   import zrb_sd_pkg::*;
#(
   parameter int NCR_MAX = 8,
   parameter int MAX_OUT = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_start,
   input  logic [5:0]                  cmd_index,
   input  logic [31:0]                 cmd_arg,
   input  logic [2:0]                  resp_extra,
   zrb_sd_cmd_framer_if.master         spi,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout,
   output logic [7:0]                  r1,
   output logic [31:0]                 resp_data
);

   localparam logic [2:0] MAX_OUT_C  = 3'(MAX_OUT);
   localparam logic [3:0] NCR_C      = 4'(NCR_MAX);
   localparam logic [3:0] NCR_LAST   = 4'(NCR_MAX - 1);

   state_t      state;
   logic [2:0]  tx_cnt;       // frame bytes issued in SEND
   logic [3:0]  rd_cnt;       // bytes read in POLL / EXTRA
   logic [2:0]  outstanding;  // sent to engine, response not yet read
   logic        rd_q;         // rx_read last cycle
   logic        to_flag;
   logic [5:0]  idx_q;
   logic [31:0] arg_q;
   logic [2:0]  extra_q;
   logic [6:0]  crc;

   logic        issuing, tx_go, rx_go;
   logic [3:0]  need;
   logic [7:0]  frame_byte;
   logic [2:0]  out_nxt;

   always_comb begin
      issuing = 1'b0;
      need    = '0;
      unique case (state)
         ST_SEND:  begin issuing = 1'b1; need = 4'd6 - {1'b0, tx_cnt};   end
         ST_POLL:  begin issuing = 1'b1; need = NCR_C - rd_cnt;          end
         ST_EXTRA: begin issuing = 1'b1; need = {1'b0, extra_q} - rd_cnt; end
         default:  ;
      endcase
   end

   always_comb begin
      frame_byte = FILL_BYTE;
      if (state == ST_SEND) begin
         unique case (tx_cnt)
            3'd0:    frame_byte = {CMD_START_BITS, idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            default: frame_byte = {crc, 1'b1};
         endcase
      end
   end

   // Never exceed the in-flight window nor ask for more bytes than the
   // phase can still consume.
   assign tx_go = issuing && !spi.tx_full && (outstanding < MAX_OUT_C) &&
                  ({1'b0, outstanding} < need);
   // One read every other cycle so the engine's empty flag has settled.
   assign rx_go = !spi.rx_empty && !rd_q &&
                  (state inside {ST_SEND, ST_POLL, ST_EXTRA, ST_DRAIN});
   assign out_nxt = outstanding + {2'b0, tx_go} - {2'b0, rx_go};

   assign spi.tx_valid = tx_go;
   assign spi.tx_data  = tx_go ? frame_byte : 8'h00;
   assign spi.rx_read  = rx_go;

   // CRC covers b0..b4 as they leave; b5 cannot issue before the cycle after b4.
   zrb_crc7 u_crc (
      .clk   (clk),
      .reset (reset),
      .clear (state == ST_IDLE),
      .en    (tx_go && state == ST_SEND && tx_cnt < 3'd5),
      .data  (frame_byte),
      .crc   (crc)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         tx_cnt      <= '0;
         rd_cnt      <= '0;
         outstanding <= '0;
         rd_q        <= 1'b0;
         to_flag     <= 1'b0;
         idx_q       <= '0;
         arg_q       <= '0;
         extra_q     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         r1          <= '0;
         resp_data   <= '0;
      end else begin
         rd_q        <= rx_go;
         outstanding <= out_nxt;
         done        <= 1'b0;
         timeout     <= 1'b0;
         unique case (state)
            ST_IDLE: if (cmd_start) begin
               idx_q     <= cmd_index;
               arg_q     <= cmd_arg;
               extra_q   <= (resp_extra > EXTRA_MAX) ? EXTRA_MAX : resp_extra;
               r1        <= '0;
               resp_data <= '0;
               tx_cnt    <= '0;
               rd_cnt    <= '0;
               to_flag   <= 1'b0;
               busy      <= 1'b1;
               state     <= ST_SEND;
            end
            ST_SEND: begin
               if (tx_go && tx_cnt != 3'd6) tx_cnt <= tx_cnt + 3'd1;
               if (tx_cnt == 3'd6 && out_nxt == 3'd0) begin
                  rd_cnt <= '0;
                  state  <= ST_POLL;
               end
            end
            ST_POLL: if (rx_go) begin
               if (!spi.rx_data[R1_START_BIT]) begin
                  r1     <= spi.rx_data;
                  rd_cnt <= '0;
                  state  <= (extra_q != 3'd0) ? ST_EXTRA : ST_DRAIN;
               end else if (rd_cnt >= NCR_LAST) begin
                  to_flag <= 1'b1;
                  state   <= ST_DRAIN;
               end else begin
                  rd_cnt <= rd_cnt + 4'd1;
               end
            end
            ST_EXTRA: if (rx_go) begin
               resp_data <= {resp_data[23:0], spi.rx_data};
               if (rd_cnt >= {1'b0, extra_q} - 4'd1) state <= ST_DRAIN;
               else                                  rd_cnt <= rd_cnt + 4'd1;
            end
            ST_DRAIN: if (out_nxt == 3'd0) state <= ST_FINISH;
            ST_FINISH: begin
               done    <= !to_flag;
               timeout <= to_flag;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      spi.rx_read |-> outstanding != 3'd0);
   a_window: assert property (@(posedge clk) disable iff (!reset)
      outstanding <= MAX_OUT_C);

endmodule

// File: tb/tb_zrb_sd_cmd_framer.sv
// Bench for zrb_sd_cmd_framer: a queue-based SPI engine + card model feeds
// the framer; each command is checked against expectations derived from the
// card script (frame bytes, R1 position, trailing bytes, fill counts).
module tb_zrb_sd_cmd_framer;
   localparam int NCR = 8;
   localparam int MO  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [2:0]  resp_extra;
   logic        busy, done, timeout;
   logic [7:0]  r1;
   logic [31:0] resp_data;

   zrb_sd_cmd_framer_if bus();

   zrb_sd_cmd_framer #(.NCR_MAX(NCR), .MAX_OUT(MO)) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
      .cmd_arg(cmd_arg), .resp_extra(resp_extra), .spi(bus), .busy(busy),
      .done(done), .timeout(timeout), .r1(r1), .resp_data(resp_data)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Card script: byte returned for fill k (k = 0 is the first 0xFF fill).
   logic [7:0] script [32];
   task automatic set_ff();
      for (int k = 0; k < 32; k++) script[k] = 8'hFF;
   endtask

   // Engine/card model state.
   logic [7:0] inq[$], outq[$], txlog[$];
   int   nbyte = 0, sh_cnt = 0, inflight = 0;
   logic sh_busy = 1'b0, force_full = 1'b0;
   logic tv = 1'b0, rr = 1'b0, rst_s = 1'b0;
   logic [7:0] td = 8'h00;
   int   done_cnt = 0, to_cnt = 0, viol = 0;

   function automatic logic [7:0] card_byte(input int n);
      if (n < 6)       return 8'($urandom_range(0, 255));  // echo during frame: junk
      else if (n < 38) return script[n - 6];
      else             return 8'hFF;
   endfunction

   // Mid-cycle: capture what the framer will do at the next edge and monitor.
   always @(negedge clk) begin
      tv = bus.tx_valid; td = bus.tx_data; rr = bus.rx_read; rst_s = reset;
      if (reset) begin
         if (tv) begin
            txlog.push_back(td);
            if (bus.tx_full) viol++;
         end
         if (rr && inflight == 0) viol++;
         inflight = inflight + int'(tv) - int'(rr);
         if (inflight > MO) viol++;
         if (done) done_cnt++;
         if (timeout) to_cnt++;
      end else inflight = 0;
   end

   // Engine: input FIFO, serial shifter with random latency, output FIFO.
   always @(posedge clk) begin
      #1;
      if (!rst_s) begin
         inq.delete(); outq.delete(); sh_busy = 1'b0; sh_cnt = 0;
      end else begin
         if (rr && outq.size() > 0) void'(outq.pop_front());
         if (tv) inq.push_back(td);
         if (sh_busy) begin
            sh_cnt--;
            if (sh_cnt == 0) begin
               outq.push_back(card_byte(nbyte)); nbyte++; sh_busy = 1'b0;
            end
         end else if (inq.size() > 0) begin
            void'(inq.pop_front()); sh_busy = 1'b1; sh_cnt = $urandom_range(1, 3);
         end
      end
      bus.tx_full  = force_full || (inq.size() >= 4);
      bus.rx_empty = (outq.size() == 0);
      bus.rx_data  = (outq.size() > 0) ? outq[0] : 8'h00;
   end

   // CRC7 as polynomial long division of the 40-bit message by 0x89.
   function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
      logic [46:0] r;
      r = {msg, 7'b0};
      for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   task automatic cyc1();
      @(posedge clk); #2;
   endtask

   task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [2:0] ext, input bit poke, input int full_at,
                          input bit rand_full);
      logic [7:0]  fr [6];
      logic [31:0] exp_resp;
      logic [7:0]  exp_r1;
      int e, f, fills, bad, full_left, v0;
      bit seen, poked, fulled;
      e = (ext > 3'd4) ? 4 : int'(ext);
      fr[0] = {2'b01, idx};
      fr[1] = arg[31:24]; fr[2] = arg[23:16]; fr[3] = arg[15:8]; fr[4] = arg[7:0];
      fr[5] = {ref_crc7({fr[0], fr[1], fr[2], fr[3], fr[4]}), 1'b1};
      f = -1;
      for (int k = 0; k < NCR; k++) if (f < 0 && !script[k][7]) f = k;
      exp_r1 = (f < 0) ? 8'h00 : script[f];
      exp_resp = '0;
      if (f >= 0) for (int j = 0; j < e; j++) exp_resp = {exp_resp[23:0], script[f + 1 + j]};

      txlog.delete(); done_cnt = 0; to_cnt = 0; nbyte = 0; v0 = viol;
      cmd_index = idx; cmd_arg = arg; resp_extra = ext; cmd_start = 1'b1;
      cyc1();
      cmd_start = 1'b0;
      seen = 0; poked = 0; fulled = 0; full_left = 0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         cmd_start = 1'b0;
         if (poke && !poked && txlog.size() >= 7) begin
            cmd_start = 1'b1; cmd_index = ~idx; poked = 1;
         end
         if (full_at > 0 && !fulled && txlog.size() == full_at) begin
            force_full = 1'b1; full_left = 10; fulled = 1;
         end else if (full_left > 0) begin
            full_left--;
            if (full_left == 0) force_full = 1'b0;
         end
         if (rand_full) force_full = ($urandom_range(0, 5) == 0);
         cyc1();
         seen = (done_cnt + to_cnt) > 0;
      end
      cmd_start = 1'b0; force_full = 1'b0;
      chk({tag, ".end"}, seen, 1);
      repeat (3) cyc1();

      chk({tag, ".done"}, done_cnt, (f >= 0) ? 1 : 0);
      chk({tag, ".tmo"}, to_cnt, (f < 0) ? 1 : 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".r1"}, r1, exp_r1);
      chk({tag, ".resp"}, resp_data, exp_resp);
      for (int k = 0; k < 6; k++) chk($sformatf("%s.b%0d", tag, k), txlog[k], fr[k]);
      fills = txlog.size() - 6;
      bad = 0;
      for (int k = 6; k < txlog.size(); k++) if (txlog[k] != 8'hFF) bad++;
      chk({tag, ".fillval"}, bad, 0);
      if (f < 0) chk({tag, ".fills"}, fills, NCR);
      else chk({tag, ".fills_rng"}, (fills >= f + 1 + e) && (fills <= f + e + MO), 1);
      chk({tag, ".bus"}, viol - v0, 0);
   endtask

   int cyc;
   logic [5:0]  ri;
   logic [31:0] ra;
   logic [2:0]  re;
   int          rf;

   initial begin
      reset = 1'b0; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_extra = '0;
      bus.tx_full = 1'b0; bus.rx_empty = 1'b1; bus.rx_data = 8'h00;
      set_ff();
      repeat (3) cyc1();
      @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.tmo", timeout, 0);
      chk("rst.r1", r1, 0);
      chk("rst.resp", resp_data, 0);
      chk("rst.txv", bus.tx_valid, 0);
      chk("rst.rxr", bus.rx_read, 0);
      cyc1();
      reset = 1'b1;
      repeat (2) cyc1();

      // CMD0, R1 on the 2nd fill.
      set_ff(); script[1] = 8'h01;
      run_cmd("cmd0", 6'd0, 32'h0, 3'd0, 0, 0, 0);
      chk("cmd0.crc", txlog[5], 8'h95);

      // CMD8 with R7 trailing bytes.
      set_ff(); script[0] = 8'h01; script[1] = 8'h00; script[2] = 8'h00;
      script[3] = 8'h01; script[4] = 8'hAA;
      run_cmd("cmd8", 6'd8, 32'h0000_01AA, 3'd4, 0, 0, 0);
      chk("cmd8.crc", txlog[5], 8'h87);
      chk("cmd8.r7", resp_data, 32'h0000_01AA);

      // CMD17, card never answers.
      set_ff();
      run_cmd("cmd17", 6'd17, 32'h0000_1200, 3'd0, 0, 0, 0);

      // Backpressure for 10 cycles mid-frame.
      set_ff(); script[0] = 8'h00;
      run_cmd("full", 6'd24, 32'hDEAD_BEEF, 3'd0, 0, 2, 0);

      // cmd_start during POLL is ignored; next command clears r1/resp_data.
      set_ff(); script[1] = 8'h01; script[2] = 8'h12; script[3] = 8'h34;
      script[4] = 8'h56; script[5] = 8'h78;
      run_cmd("poke", 6'd58, 32'h4000_0000, 3'd4, 1, 0, 0);
      set_ff();
      run_cmd("fresh", 6'd41, 32'h4000_0000, 3'd0, 0, 0, 0);

      // Reset during EXTRA.
      set_ff(); script[0] = 8'h01; script[1] = 8'h00; script[2] = 8'h00;
      script[3] = 8'h01; script[4] = 8'hAA;
      txlog.delete(); done_cnt = 0; to_cnt = 0; nbyte = 0;
      cmd_index = 6'd8; cmd_arg = 32'h1AA; resp_extra = 3'd4; cmd_start = 1'b1;
      cyc1();
      cmd_start = 1'b0;
      for (cyc = 0; cyc < 500 && r1 == 8'h00; cyc++) cyc1();
      chk("xrst.r1seen", r1, 8'h01);
      chk("xrst.busy_pre", busy, 1);
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("xrst.out", {busy, done, timeout, r1, resp_data, bus.tx_valid, bus.rx_read, bus.tx_data}, 0);
      cyc1();
      reset = 1'b1;
      repeat (20) cyc1();
      chk("xrst.nopulse", done_cnt + to_cnt, 0);
      run_cmd("xrst.after", 6'd8, 32'h0000_01AA, 3'd4, 0, 0, 0);

      // Randomized commands with random backpressure.
      for (int t = 0; t < 25; t++) begin
         for (int k = 0; k < 32; k++) script[k] = 8'($urandom_range(0, 255));
         rf = $urandom_range(0, NCR + 1);
         for (int k = 0; k < rf; k++) script[k][7] = 1'b1;
         script[rf][7] = 1'b0;
         ri = 6'($urandom_range(0, 63));
         ra = $urandom;
         re = 3'($urandom_range(0, 7));
         run_cmd($sformatf("rnd%0d", t), ri, ra, re, 0, 0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
